// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results in per-source FIFOs and
// broadcasts one registered (robIndex, value) pair per cycle with round-robin fairness.
module cdb_arbiter #(
  parameter int ROB_WIDTH   = 4,
  parameter int QUEUE_WIDTH = 1
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 flushIn,
  input  logic                 aluValid,
  input  logic [ROB_WIDTH-1:0] aluRobIndex,
  input  logic [31:0]          aluVal,
  output logic                 aluReady,
  input  logic                 lsbValid,
  input  logic [ROB_WIDTH-1:0] lsbRobIndex,
  input  logic [31:0]          lsbVal,
  output logic                 lsbReady,
  output logic                 cdbValid,
  output logic [ROB_WIDTH-1:0] cdbRobIndex,
  output logic [31:0]          cdbVal,
  output logic                 cdbSource
);

  localparam int DEPTH = 2 ** QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] FULL_COUNT = (QUEUE_WIDTH + 1)'(DEPTH);

  // Index 0 is the ALU queue, index 1 the LSB queue, matching cdbSource.
  logic [ROB_WIDTH-1:0]   robQ    [2][DEPTH];
  logic [31:0]            valQ    [2][DEPTH];
  logic [QUEUE_WIDTH-1:0] headPtr [2];
  logic [QUEUE_WIDTH-1:0] tailPtr [2];
  logic [QUEUE_WIDTH:0]   count   [2];
  logic                   lastGrant;

  logic [1:0]           srcValid;
  logic [1:0]           srcReady;
  logic [1:0]           srcPush;
  logic [1:0]           srcPop;
  logic [1:0]           nonEmpty;
  logic [ROB_WIDTH-1:0] srcRob [2];
  logic [31:0]          srcVal [2];
  logic                 grantAny;
  logic                 grantId;

  always_comb begin
    srcValid  = {lsbValid, aluValid};
    srcRob[0] = aluRobIndex;
    srcRob[1] = lsbRobIndex;
    srcVal[0] = aluVal;
    srcVal[1] = lsbVal;
    for (int s = 0; s < 2; s++) begin
      srcReady[s] = (count[s] != FULL_COUNT);
      nonEmpty[s] = (count[s] != '0);
    end
    // On a tie the source that did not win last time gets the bus.
    grantAny = |nonEmpty;
    grantId  = (&nonEmpty) ? ~lastGrant : nonEmpty[1];
    srcPop   = 2'b00;
    if (grantAny) srcPop[grantId] = 1'b1;
    srcPush  = srcValid & srcReady & {2{~flushIn}};
  end

  assign aluReady = srcReady[0];
  assign lsbReady = srcReady[1];

  always_ff @(posedge clockIn) begin
    for (int s = 0; s < 2; s++) begin
      if (srcPush[s]) begin
        robQ[s][tailPtr[s]] <= srcRob[s];
        valQ[s][tailPtr[s]] <= srcVal[s];
      end
    end
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      for (int s = 0; s < 2; s++) begin
        headPtr[s] <= '0;
        tailPtr[s] <= '0;
        count[s]   <= '0;
      end
      lastGrant   <= 1'b1;
      cdbValid    <= 1'b0;
      cdbRobIndex <= '0;
      cdbVal      <= '0;
      cdbSource   <= 1'b0;
    end else if (flushIn) begin
      for (int s = 0; s < 2; s++) begin
        headPtr[s] <= '0;
        tailPtr[s] <= '0;
        count[s]   <= '0;
      end
      lastGrant <= 1'b1;
      cdbValid  <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (srcPush[s]) tailPtr[s] <= tailPtr[s] + 1'b1;
        if (srcPop[s])  headPtr[s] <= headPtr[s] + 1'b1;
        if (srcPush[s] && !srcPop[s])      count[s] <= count[s] + 1'b1;
        else if (srcPop[s] && !srcPush[s]) count[s] <= count[s] - 1'b1;
      end
      // Idle cycles keep the last broadcast payload; only the valid bit drops.
      if (grantAny) begin
        cdbValid    <= 1'b1;
        cdbRobIndex <= robQ[grantId][headPtr[grantId]];
        cdbVal      <= valQ[grantId][headPtr[grantId]];
        cdbSource   <= grantId;
        lastGrant   <= grantId;
      end else begin
        cdbValid <= 1'b0;
      end
    end
  end

endmodule
